// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory port arbiter and lane control.
// Contents: access-size codes, read-return owner tags, arbiter FSM states, lane count.
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int LANES = 4;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DBG = 2'd2} owner_t;
    typedef enum logic {ARB = 1'b0, DBG_LOCK = 1'b1} arb_state_t;
endpackage

// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: maps access size + byte offset to lane enables and replicated write data.
// Ports: i_size (access size), i_off (byte offset), i_wdata (right-aligned store data),
//        o_lanes (per-lane enables), o_wdata (lane-replicated data), o_illegal (bad size/alignment).
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_off,
    input  logic [31:0]      i_wdata,
    output logic [LANES-1:0] o_lanes,
    output logic [31:0]      o_wdata,
    output logic             o_illegal
);
    always_comb begin
        o_illegal = (i_size == 2'b11) || (i_size == SZ_HALF && i_off[0]) || (i_size == SZ_WORD && i_off != 2'b00);
        o_lanes   = o_illegal          ? 4'b0000 :
                    i_size == SZ_BYTE  ? 4'b0001 << i_off :
                    i_size == SZ_HALF  ? (i_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_wdata   = i_size == SZ_BYTE  ? {4{i_wdata[7:0]}} :
                    i_size == SZ_HALF  ? {2{i_wdata[15:0]}} : i_wdata;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the byte-lane data RAMs between the CPU (priority) and DBG ports.
// Ports: CPU request/stall/read return, DBG request/grant/read return, RAM address/data/enables,
//        MisalignErr pulse. Optional DBG lock (input DbgLock) under macro DMEM_ARB_LOCK_EN.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_LSB = 2,
    parameter int AW       = 13
) (
`ifdef DMEM_ARB_LOCK_EN
    input  logic          DbgLock,
`endif
    input  logic          clk,
    input  logic          rst,
    input  logic          CpuReq,
    input  logic          CpuWe,
    input  logic [1:0]    CpuSize,
    input  logic [31:0]   CpuAddr,
    input  logic [31:0]   CpuWData,
    output logic          CpuStall,
    output logic          CpuRValid,
    output logic [31:0]   CpuRData,
    input  logic          DbgReq,
    input  logic          DbgWe,
    input  logic [1:0]    DbgSize,
    input  logic [31:0]   DbgAddr,
    input  logic [31:0]   DbgWData,
    output logic          DbgGnt,
    output logic          DbgRValid,
    output logic [31:0]   DbgRData,
    output logic [AW-1:0] MemAddr,
    output logic [31:0]   MemWData,
    output logic          MemRden,
    output logic [3:0]    MemWren,
    input  logic [31:0]   MemRData,
    output logic          MisalignErr
);
    localparam logic [3:0] MW = 4'(MAX_WAIT);
    arb_state_t r_state, w_next;
    owner_t     r_owner;
    logic [3:0] r_wait;
    logic       r_err;
    logic       w_locked, w_dbg_win, w_cpu_win, w_any, w_we, w_ill, w_unused;
    logic [1:0] w_size;
    logic [3:0] w_lanes;
    logic [31:0] w_addr, w_wdata, w_rep;

    dmem_lane_ctrl u_lane (
        .i_size   (w_size),
        .i_off    (w_addr[1:0]),
        .i_wdata  (w_wdata),
        .o_lanes  (w_lanes),
        .o_wdata  (w_rep),
        .o_illegal(w_ill)
    );

    always_ff @(posedge clk) begin
        r_state <= rst ? ARB : w_next;
    end

    // Entering and staying in DBG_LOCK both reduce to "DBG granted while holding DbgLock".
    always_comb begin
        w_next = ARB;
`ifdef DMEM_ARB_LOCK_EN
        w_next = (w_dbg_win && DbgLock) ? DBG_LOCK : ARB;
`endif
    end

    always_comb begin
        w_locked  = r_state == DBG_LOCK;
        w_dbg_win = DbgReq && (!CpuReq || r_wait == MW || w_locked);
        w_cpu_win = CpuReq && !w_dbg_win && !w_locked;
        w_any     = w_cpu_win || w_dbg_win;
        w_we      = w_dbg_win ? DbgWe    : CpuWe;
        w_size    = w_dbg_win ? DbgSize  : CpuSize;
        w_addr    = w_dbg_win ? DbgAddr  : CpuAddr;
        w_wdata   = w_dbg_win ? DbgWData : CpuWData;
        DbgGnt    = w_dbg_win;
        CpuStall  = CpuReq && !w_cpu_win;
        MemAddr   = w_any ? w_addr[ADDR_LSB+AW-1:ADDR_LSB] : '0;
        MemWData  = w_any ? w_rep : '0;
        MemRden   = w_any && !w_we && !w_ill;
        MemWren   = (w_any && w_we) ? w_lanes : 4'b0000;
        w_unused  = &{1'b0, w_addr[31:ADDR_LSB+AW]};
    end

    // WaitCnt counts contested cycles DBG lost; cleared by any DBG grant and pinned while locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
        end else begin
            r_wait  <= (w_dbg_win || w_locked) ? 4'd0 :
                       (CpuReq && DbgReq && r_wait != MW) ? r_wait + 4'd1 : r_wait;
            r_owner <= MemRden ? (w_dbg_win ? OWN_DBG : OWN_CPU) : OWN_NONE;
            r_err   <= w_any && w_ill;
        end
    end

    assign CpuRValid   = r_owner == OWN_CPU;
    assign DbgRValid   = r_owner == OWN_DBG;
    assign CpuRData    = CpuRValid ? MemRData : '0;
    assign DbgRData    = DbgRValid ? MemRData : '0;
    assign MisalignErr = r_err;
endmodule
